fir_mac_engine: RTL
===================

FIR_MAC_ENGINE -- requirements
Module: fir_mac_engine

Interface
REQ-001 SHALL have parameter NTaps, default 13, filter length (>=2).
REQ-002 SHALL have parameter DataWidth, default 8, signed sample width.
REQ-003 SHALL have parameter CoeffWidth, default 8, signed coefficient width, Q1.(CoeffWidth-1).
REQ-004 SHALL have parameter NChannels, default 2, independent delay lines sharing one coefficient set.
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port resetN  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port inValid  in  1 / inReady  out  1  input sample handshake.
REQ-008 SHALL have port inData  in  DataWidth  signed sample; inChannel  in  max(1,$clog2(NChannels))  target channel.
REQ-009 SHALL have port outValid  out  1 / outReady  in  1  result handshake.
REQ-010 SHALL have port outData  out  DataWidth  signed result; outChannel  out  max(1,$clog2(NChannels))  channel of result.
REQ-011 SHALL have port coeffWe  in  1, coeffAddr  in  max(1,$clog2(NTaps)), coeffData  in  CoeffWidth: coefficient write.
REQ-012 SHALL have port coeffAck  out  1  one-cycle pulse when a write is applied.
REQ-013 SHALL have port bypass  in  1  pass-through mode; clear  in  1  zero all delay lines.

Function
REQ-014 SHALL implement states IDLE, MAC, OUT; one shared multiplier, one tap per cycle.
REQ-015 SHALL assert inReady only in IDLE; accept when inValid && inReady at a rising edge.
REQ-016 On accept, SHALL shift inData into delay line inChannel (x[0] newest, x[NTaps-1] dropped), latch channel, clear accumulator, go to MAC (bypass=0) or OUT (bypass=1).
REQ-017 MAC SHALL run exactly NTaps cycles, k = 0..NTaps-1, acc += coeff[k] * x_ch[k], then go to OUT.
REQ-018 Accumulator SHALL be DataWidth+CoeffWidth+$clog2(NTaps) bits signed; no intermediate overflow.
REQ-019 Result SHALL be acc arithmetically shifted right by CoeffWidth-1 (floor), saturated to [-2^(DataWidth-1), 2^(DataWidth-1)-1].
REQ-020 In bypass, outData SHALL equal the accepted inData; delay line still updated.
REQ-021 outValid SHALL be high exactly in OUT; outData/outChannel stable while outValid && !outReady.
REQ-022 OUT SHALL return to IDLE on the edge where outReady is high; no new input accepted in that same cycle.
REQ-023 Latency: outValid high NTaps+1 edges after the accepting edge (1 edge in bypass), with outReady held high.
REQ-024 Coefficient write SHALL apply only when state is IDLE and coeffAddr < NTaps; coeffAck pulses the following cycle.
REQ-025 coeffWe in MAC/OUT or with coeffAddr >= NTaps SHALL be ignored, no coeffAck.
REQ-026 clear in IDLE SHALL zero all delay lines of all channels; ignored otherwise; clear with a simultaneous accept: clear first, then shift.
REQ-027 inChannel >= NChannels SHALL be accepted and discarded: no delay-line change, no output, stays IDLE.
REQ-028 bypass SHALL be sampled only at accept; changes mid-operation have no effect.

Reset
REQ-029 On resetN low, SHALL immediately set state IDLE, outValid 0, outData 0, outChannel 0, coeffAck 0, accumulator 0.
REQ-030 Reset SHALL zero all delay lines and all coefficients; inReady 1 from first edge after release.
REQ-031 Reset mid-MAC or mid-OUT SHALL discard the result with no outValid pulse.

Verification (NTaps=13, DataWidth=8, CoeffWidth=8, NChannels=2)
REQ-032 coeff[k]=k+1, ch0 impulse 64 then 12 zeros, outReady=1 -> outData 0,1,1,2,2,3,3,4,4,5,5,6,6; each outValid 14 edges after accept.
REQ-033 all coeff 127, thirteen ch0 samples 127 -> last output 127 (acc 209677 saturated); then thirteen -128 -> -128.
REQ-034 interleave ch0 impulse 64 with ch1 zeros -> all ch1 outputs 0, outChannel=1; ch0 sequence unchanged from REQ-032.
REQ-035 outReady low 5 cycles in OUT -> outValid, outData, outChannel stable, inReady 0; release -> IDLE next edge.
REQ-036 coeffWe during MAC, or coeffAddr=13 -> no coeffAck, coefficients unchanged; same write in IDLE -> coeffAck one cycle.
REQ-037 resetN low during MAC cycle 6 -> no outValid, inReady 1 after release; impulse 64 with coeffs 0 -> output 0.

Source files
------------

// File: rtl/fir_mac_engine.sv
// fir_mac_engine: multichannel time-multiplexed FIR filter.
// One shared multiplier walks the taps of the selected channel's delay line,
// one tap per clock, and the scaled, saturated result is handed out through a
// valid/ready handshake. All channels share one writable coefficient set.
module fir_mac_engine #(
    parameter int NTaps      = 13,
    parameter int DataWidth  = 8,
    parameter int CoeffWidth = 8,
    parameter int NChannels  = 2,
    localparam int ChW       = (NChannels > 1) ? $clog2(NChannels) : 1,
    localparam int AddrW     = (NTaps > 1) ? $clog2(NTaps) : 1
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         inValid,
    output logic                         inReady,
    input  logic signed [DataWidth-1:0]  inData,
    input  logic        [ChW-1:0]        inChannel,
    output logic                         outValid,
    input  logic                         outReady,
    output logic signed [DataWidth-1:0]  outData,
    output logic        [ChW-1:0]        outChannel,
    input  logic                         coeffWe,
    input  logic        [AddrW-1:0]      coeffAddr,
    input  logic signed [CoeffWidth-1:0] coeffData,
    output logic                         coeffAck,
    input  logic                         bypass,
    input  logic                         clear
);

    // Accumulator is wide enough that NTaps full-scale products never overflow.
    localparam int AccW = DataWidth + CoeffWidth + $clog2(NTaps);
    localparam int PW   = DataWidth + CoeffWidth;

    localparam logic signed [AccW-1:0] SAT_MAX =
        {{(AccW-DataWidth+1){1'b0}}, {(DataWidth-1){1'b1}}};
    localparam logic signed [AccW-1:0] SAT_MIN =
        {{(AccW-DataWidth+1){1'b1}}, {(DataWidth-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t state_r;
    state_t state_n_s;

    logic signed [DataWidth-1:0]  line_r  [NChannels][NTaps];
    logic signed [CoeffWidth-1:0] coeff_r [NTaps];
    logic signed [AccW-1:0]       acc_r;
    logic signed [AccW-1:0]       acc_next_s;
    logic signed [PW-1:0]         prod_s;
    logic        [AddrW-1:0]      k_r;
    logic        [ChW-1:0]        ch_r;
    logic                         in_ready_r;
    logic                         out_valid_r;
    logic signed [DataWidth-1:0]  out_data_r;
    logic        [ChW-1:0]        out_ch_r;
    logic                         coeff_ack_r;

    logic accept_s;
    logic ch_ok_s;
    logic accept_ok_s;
    logic clear_now_s;
    logic coeff_wr_s;
    logic last_tap_s;

    // Scale a Q(CoeffWidth-1) accumulator back to sample format with floor and saturation.
    function automatic logic signed [DataWidth-1:0] sat_result(input logic signed [AccW-1:0] acc);
        logic signed [AccW-1:0] sh;
        sh = acc >>> (CoeffWidth - 1);
        if (sh > SAT_MAX) begin
            sat_result = SAT_MAX[DataWidth-1:0];
        end else if (sh < SAT_MIN) begin
            sat_result = SAT_MIN[DataWidth-1:0];
        end else begin
            sat_result = sh[DataWidth-1:0];
        end
    endfunction

    // An accepted sample for a non-existent channel is swallowed without effect.
    assign accept_s    = inValid && in_ready_r;
    assign ch_ok_s     = (32'(inChannel) < 32'(NChannels));
    assign accept_ok_s = accept_s && ch_ok_s;
    assign clear_now_s = clear && (state_r == ST_IDLE);
    assign coeff_wr_s  = coeffWe && (state_r == ST_IDLE) && (32'(coeffAddr) < 32'(NTaps));
    assign last_tap_s  = (k_r == AddrW'(NTaps - 1));

    assign prod_s     = PW'(coeff_r[k_r]) * PW'(line_r[ch_r][k_r]);
    assign acc_next_s = acc_r + AccW'(prod_s);

    // Next-state logic for the IDLE -> MAC -> OUT sequence.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_ok_s) begin
                    state_n_s = bypass ? ST_OUT : ST_MAC;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (last_tap_s) begin
                    state_n_s = ST_OUT;
                end else begin
                    state_n_s = ST_MAC;
                end
            end
            ST_OUT: begin
                if (outReady) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_OUT;
                end
            end
            default: state_n_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Delay lines: clear takes effect before a same-cycle shift.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int c = 0; c < NChannels; c++) begin
                for (int t = 0; t < NTaps; t++) begin
                    line_r[c][t] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < NChannels; c++) begin
                if (accept_ok_s && (inChannel == ChW'(c))) begin
                    line_r[c][0] <= inData;
                    for (int t = 1; t < NTaps; t++) begin
                        line_r[c][t] <= clear_now_s ? '0 : line_r[c][t-1];
                    end
                end else if (clear_now_s) begin
                    for (int t = 0; t < NTaps; t++) begin
                        line_r[c][t] <= '0;
                    end
                end
            end
        end
    end

    // Coefficient store and its write acknowledge.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int t = 0; t < NTaps; t++) begin
                coeff_r[t] <= '0;
            end
            coeff_ack_r <= 1'b0;
        end else begin
            if (coeff_wr_s) begin
                coeff_r[coeffAddr] <= coeffData;
            end
            coeff_ack_r <= coeff_wr_s;
        end
    end

    // Tap counter, accumulator and latched channel for the MAC walk.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            acc_r <= '0;
            k_r   <= '0;
            ch_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_ok_s) begin
                        acc_r <= '0;
                        k_r   <= '0;
                        ch_r  <= inChannel;
                    end
                end
                ST_MAC: begin
                    acc_r <= acc_next_s;
                    k_r   <= last_tap_s ? '0 : k_r + AddrW'(1);
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    // Registered handshake outputs; result is captured on entry to OUT and held.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_ch_r    <= '0;
        end else begin
            in_ready_r  <= (state_n_s == ST_IDLE);
            out_valid_r <= (state_n_s == ST_OUT);
            if ((state_r == ST_IDLE) && accept_ok_s && bypass) begin
                out_data_r <= inData;
                out_ch_r   <= inChannel;
            end else if ((state_r == ST_MAC) && last_tap_s) begin
                out_data_r <= sat_result(acc_next_s);
                out_ch_r   <= ch_r;
            end
        end
    end

    assign inReady    = in_ready_r;
    assign outValid   = out_valid_r;
    assign outData    = out_data_r;
    assign outChannel = out_ch_r;
    assign coeffAck   = coeff_ack_r;

endmodule
